instr_fetch_unit: RTL and testbench

- Multicycle instruction fetch initiator that drives the combinational, byte-addressed, read-only instruction memory.
- Holds the fetch PC and presents it on imem_addr.
- Waits a fixed number of memory wait cycles, then latches the returned word into the instruction register.
- Hands the word to the control/decode stage with a valid/ready handshake; accepts PC redirects for jumps and branches.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/instr_fetch_unit.sv | 133 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  // The memory ignores the byte offset; the word index is the upper address bits.
  function automatic logic [ADDR_W-3:0] word_index(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch initiator: presents the fetch PC to a
// combinational instruction memory, waits MEM_WAIT cycles, latches the word
// and offers it to decode with a valid/ready handshake. Redirects reload the
// fetch PC from any state; misaligned or out-of-range fetches park in FAULT.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned MEM_WAIT   = 0,
  parameter int unsigned IMEM_WORDS = 7
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fault
);

  localparam logic [3:0]        WAIT_LAST = 4'(MEM_WAIT);
  localparam logic [31:0]       PC_STEP   = 32'(WORD_BYTES);
  localparam logic [ADDR_W-3:0] WORD_LIM  = (ADDR_W-2)'(IMEM_WORDS);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic [31:0] r_fetch_pc;
  logic [31:0] r_ir;
  logic [31:0] r_pc;
  logic [31:0] r_pc_plus4;
  logic        r_ir_valid;
  logic        r_fault;
  logic [3:0]  r_wait_cnt;

  logic w_addr_bad;
  logic w_wait_inc;
  logic w_sample;
  logic w_consume;
  logic w_enter_fault;

  // Address checker: a bad address is caught before the memory is ever sampled.
  assign w_addr_bad = (r_fetch_pc[1:0] != 2'b00) || (word_index(r_fetch_pc) >= WORD_LIM);

  // Next-state and datapath strobes; redirect overrides every state.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    w_state_nxt   = r_state;
    w_wait_inc    = 1'b0;
    w_sample      = 1'b0;
    w_consume     = 1'b0;
    w_enter_fault = 1'b0;
    if (redirect) begin
      w_state_nxt = FETCH;
    end else begin
      unique case (r_state)
        FETCH: begin
          if (w_addr_bad) begin
            w_enter_fault = 1'b1;
            w_state_nxt   = FAULT;
          end else if (r_wait_cnt == WAIT_LAST) begin
            w_sample    = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_wait_inc = 1'b1;
          end
        end
        HOLD: begin
          if (ir_ready) begin
            w_consume   = 1'b1;
            w_state_nxt = FETCH;
          end
        end
        FAULT:   w_state_nxt = FAULT;
        default: w_state_nxt = FETCH;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (rst) r_state <= FETCH;
    else     r_state <= w_state_nxt;
  end

  // Fetch PC, wait counter, instruction register and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_ir       <= '0;
      r_pc       <= '0;
      r_pc_plus4 <= PC_STEP;
      r_ir_valid <= 1'b0;
      r_fault    <= 1'b0;
      r_wait_cnt <= '0;
    end else if (redirect) begin
      // Squashes any held instruction; with ir_ready it counts as consumed.
      r_fetch_pc <= redirect_pc;
      r_wait_cnt <= '0;
      r_ir_valid <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      if (w_wait_inc) r_wait_cnt <= r_wait_cnt + 4'd1;
      if (w_sample) begin
        r_ir       <= imem_rdata;
        r_pc       <= r_fetch_pc;
        r_pc_plus4 <= r_fetch_pc + PC_STEP;
        // Advance immediately so the memory settles while decode works.
        r_fetch_pc <= r_fetch_pc + PC_STEP;
        r_ir_valid <= 1'b1;
        r_wait_cnt <= '0;
      end
      if (w_consume)     r_ir_valid <= 1'b0;
      if (w_enter_fault) r_fault    <= 1'b1;
    end
  end

  assign imem_addr    = r_fetch_pc;
  assign ir_out       = r_ir;
  assign pc_out       = r_pc;
  assign pc_plus4_out = r_pc_plus4;
  assign ir_valid     = r_ir_valid;
  assign fault        = r_fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a table of per-cycle vectors drives a
// MEM_WAIT=1 instance, and a short hand-written sequence drives a MEM_WAIT=0
// instance. Both share one combinational ROM model.
module tb_instr_fetch_unit;

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          redir;
    logic [31:0] rpc;
    bit          exp_valid;
    bit          exp_fault;
    logic [31:0] exp_addr;
    bit          chk_data;
    logic [31:0] exp_pc;
    logic [31:0] exp_ir;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // MEM_WAIT = 1 instance
  logic        rst1 = 1'b1, rdy1 = 1'b0, redir1 = 1'b0;
  logic [31:0] rpc1 = '0;
  logic [31:0] addr1, rdata1, ir1, pc1, pc4_1;
  logic        valid1, fault1;

  // MEM_WAIT = 0 instance
  logic        rst0 = 1'b1, rdy0 = 1'b0, redir0 = 1'b0;
  logic [31:0] rpc0 = '0;
  logic [31:0] addr0, rdata0, ir0, pc0, pc4_0;
  logic        valid0, fault0;

  int n_vec  = 0;
  int n_miss = 0;

  // ROM: words 0..6 hold 0x1000_0000 + index, anything else reads as garbage.
  function automatic logic [31:0] rom(input logic [31:0] a);
    logic [29:0] idx;
    idx = a[31:2];
    return (idx < 30'd7) ? (32'h1000_0000 + {2'b00, idx}) : 32'hDEAD_BEEF;
  endfunction

  assign rdata1 = rom(addr1);
  assign rdata0 = rom(addr0);

  instr_fetch_unit #(.RESET_PC(32'h0), .MEM_WAIT(1), .IMEM_WORDS(7)) u_dut1 (
    .clk(clk), .rst(rst1), .imem_addr(addr1), .imem_rdata(rdata1),
    .ir_out(ir1), .pc_out(pc1), .pc_plus4_out(pc4_1), .ir_valid(valid1),
    .ir_ready(rdy1), .redirect(redir1), .redirect_pc(rpc1), .fault(fault1)
  );

  instr_fetch_unit #(.RESET_PC(32'h0), .MEM_WAIT(0), .IMEM_WORDS(7)) u_dut0 (
    .clk(clk), .rst(rst0), .imem_addr(addr0), .imem_rdata(rdata0),
    .ir_out(ir0), .pc_out(pc0), .pc_plus4_out(pc4_0), .ir_valid(valid0),
    .ir_ready(rdy0), .redirect(redir0), .redirect_pc(rpc0), .fault(fault0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit rst, input bit rdy, input bit redir, input int rpc,
                              input bit v, input bit f, input int addr,
                              input bit chk, input int pc, input int ir);
    vec_t t;
    t.rst = rst; t.rdy = rdy; t.redir = redir; t.rpc = 32'(rpc);
    t.exp_valid = v; t.exp_fault = f; t.exp_addr = 32'(addr);
    t.chk_data = chk; t.exp_pc = 32'(pc); t.exp_ir = 32'(ir);
    return t;
  endfunction

  // Drive one vector, let one rising edge pass, then compare away from the edge.
  task automatic apply1(input vec_t v, input int idx);
    rst1 = v.rst; rdy1 = v.rdy; redir1 = v.redir; rpc1 = v.rpc;
    @(posedge clk); #1;
    check($sformatf("v%0d ir_valid", idx), 32'(valid1), 32'(v.exp_valid));
    check($sformatf("v%0d fault", idx), 32'(fault1), 32'(v.exp_fault));
    check($sformatf("v%0d imem_addr", idx), addr1, v.exp_addr);
    if (v.chk_data) begin
      check($sformatf("v%0d pc_out", idx), pc1, v.exp_pc);
      check($sformatf("v%0d ir_out", idx), ir1, v.exp_ir);
      check($sformatf("v%0d pc_plus4_out", idx), pc4_1, v.exp_pc + 32'd4);
    end
  endtask

  vec_t vecs[$];

  initial begin
    // ---- vector table for the MEM_WAIT=1 instance ----
    // Reset state.
    vecs.push_back(mk(1,0,0,0,  0,0,0,  1,0,0));
    // Straight-line fetch of words 0..6 with ready high: wait, sample, consume.
    for (int k = 0; k < 7; k++) begin
      if (k != 0) vecs.push_back(mk(0,1,0,0, 0,0,4*k, 0,0,0)); // consume
      vecs.push_back(mk(0,1,0,0, 0,0,4*k, 0,0,0));             // wait cycle
      vecs.push_back(mk(0,1,0,0, 1,0,4*k+4, 1,4*k,32'h1000_0000+k));
    end
    // Word 7 is out of range: consume, then fault, then stay faulted.
    vecs.push_back(mk(0,1,0,0, 0,0,28, 0,0,0));
    vecs.push_back(mk(0,1,0,0, 0,1,28, 0,0,0));
    vecs.push_back(mk(0,1,0,0, 0,1,28, 0,0,0));
    // Redirect to misaligned 0x06, fault, then redirect to 0 and fetch word 0.
    vecs.push_back(mk(0,1,1,6, 0,0,6, 0,0,0));
    vecs.push_back(mk(0,1,0,0, 0,1,6, 0,0,0));
    vecs.push_back(mk(0,1,1,0, 0,0,0, 0,0,0));
    vecs.push_back(mk(0,1,0,0, 0,0,0, 0,0,0));
    vecs.push_back(mk(0,1,0,0, 1,0,4, 1,0,32'h1000_0000));
    // Redirect to 0x0C together with ready while holding pc_out=0.
    vecs.push_back(mk(0,1,1,12, 0,0,12, 0,0,0));
    vecs.push_back(mk(0,1,0,0,  0,0,12, 0,0,0));
    vecs.push_back(mk(0,1,0,0,  1,0,16, 1,12,32'h1000_0003));
    // Squash redirect to 0x08 without ready, then 5 cycles of backpressure.
    vecs.push_back(mk(0,0,1,8, 0,0,8, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,8, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,0,12, 1,8,32'h1000_0002));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,0,0,0, 1,0,12, 1,8,32'h1000_0002));
    vecs.push_back(mk(0,1,0,0, 0,0,12, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,12, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,0,16, 1,12,32'h1000_0003));
    // Consume, enter the wait cycle, then reset together with a redirect.
    vecs.push_back(mk(0,1,0,0,  0,0,16, 0,0,0));
    vecs.push_back(mk(0,0,0,0,  0,0,16, 0,0,0));
    vecs.push_back(mk(1,1,1,16, 0,0,0,  1,0,0));
    // Wait restarts from zero: one wait cycle, then word 0.
    vecs.push_back(mk(0,1,0,0,  0,0,0,  0,0,0));
    vecs.push_back(mk(0,1,0,0,  1,0,4,  1,0,32'h1000_0000));

    foreach (vecs[i]) apply1(vecs[i], i);

    // ---- MEM_WAIT=0 instance: one-cycle latency, one fetch every 2 cycles ----
    rst0 = 1'b1; rdy0 = 1'b0;
    @(posedge clk); #1;
    check("w0 reset ir_valid", 32'(valid0), 32'd0);
    check("w0 reset imem_addr", addr0, 32'd0);
    check("w0 reset pc_plus4_out", pc4_0, 32'd4);
    rst0 = 1'b0; rdy0 = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      if (e % 2 == 1) begin
        check($sformatf("w0 e%0d ir_valid", e), 32'(valid0), 32'd1);
        check($sformatf("w0 e%0d pc_out", e), pc0, 32'(2*(e-1)));
        check($sformatf("w0 e%0d ir_out", e), ir0, 32'h1000_0000 + 32'((e-1)/2));
        check($sformatf("w0 e%0d imem_addr", e), addr0, 32'(2*e+2));
      end else begin
        check($sformatf("w0 e%0d ir_valid", e), 32'(valid0), 32'd0);
        check($sformatf("w0 e%0d imem_addr", e), addr0, 32'(2*e));
      end
      check($sformatf("w0 e%0d fault", e), 32'(fault0), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
